// File: rtl/ts_packet_framer_pkg.sv
// Shared constants and types for the MPEG-TS packet framer.
package ts_packet_framer_pkg;

  localparam int         TS_PKT_LEN   = 188;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

  // FIFO read word layout: {data[7:0], valid, sync}
  localparam int TS_WORD_W   = 10;
  localparam int TS_DATA_HI  = 9;
  localparam int TS_DATA_LO  = 2;
  localparam int TS_VLD_BIT  = 1;
  localparam int TS_SYNC_BIT = 0;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } ts_state_e;

  function automatic logic ts_is_cand(input logic [TS_WORD_W-1:0] w, input logic [7:0] sync_byte);
    return (w[TS_DATA_HI:TS_DATA_LO] == sync_byte) && w[TS_SYNC_BIT];
  endfunction

endpackage

// File: rtl/ts_packet_framer.sv
// TS framer: hunts for sync bytes in a FIFO byte stream, locks after LOCK_THR good syncs and emits framed packets.
// Output is a registered valid/ready stage with a one-entry skid that absorbs the word already in flight from the FIFO.
module ts_packet_framer
  import ts_packet_framer_pkg::*;
#(
  parameter int         PKT_LEN   = TS_PKT_LEN,
  parameter logic [7:0] SYNC_BYTE = TS_SYNC_BYTE,
  parameter int         LOCK_THR  = 3,
  parameter int         LOSS_THR  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TS_WORD_W-1:0] fifo_dout,
  input  logic                 fifo_empty,
  output logic                 r_en,
  input  logic                 out_ready,
  output logic [7:0]           ts_data,
  output logic                 ts_valid,
  output logic                 ts_sop,
  output logic                 ts_eop,
  output logic                 locked,
  output logic [31:0]          pkt_count,
  output logic [31:0]          sync_err_count
);

  localparam int               IDX_W    = $clog2(PKT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  ts_state_e        state, state_nxt;
  logic [IDX_W-1:0] byte_idx, idx_nxt;
  logic [7:0]       good, good_nxt;
  logic [7:0]       miss, miss_nxt;

  logic       rd_pend;
  logic       skid_vld;
  logic [7:0] skid_data;
  logic       skid_sop;
  logic       skid_eop;

  logic       out_free;
  logic       rd_req;
  logic       word_in;
  logic       cand;
  logic [7:0] w_data;
  logic       emit;
  logic       sync_miss;

  assign out_free = ~ts_valid | out_ready;
  assign rd_req   = ~fifo_empty & out_free;
  assign r_en     = rst & rd_req;
  assign word_in  = rd_pend & fifo_dout[TS_VLD_BIT];
  assign w_data   = fifo_dout[TS_DATA_HI:TS_DATA_LO];
  assign cand     = ts_is_cand(fifo_dout, SYNC_BYTE);
  assign locked   = (state == LOCK);

  always_comb begin
    state_nxt = state;
    idx_nxt   = byte_idx;
    good_nxt  = good;
    miss_nxt  = miss;
    emit      = 1'b0;
    sync_miss = 1'b0;
    if (word_in) begin
      if (state != HUNT) idx_nxt = (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
      unique case (state)
        HUNT: begin
          if (cand) begin
            state_nxt = VERIFY;
            idx_nxt   = IDX_W'(1);
            good_nxt  = 8'd1;
          end
        end
        VERIFY: begin
          if (byte_idx == '0) begin
            if (cand) begin
              good_nxt = good + 8'd1;
              if (good_nxt == 8'(LOCK_THR)) begin
                state_nxt = LOCK;
                miss_nxt  = 8'd0;
                emit      = 1'b1;
              end
            end else begin
              state_nxt = HUNT;
              idx_nxt   = '0;
              good_nxt  = 8'd0;
            end
          end
        end
        LOCK: begin
          emit = 1'b1;
          if (byte_idx == '0) begin
            if (cand) begin
              miss_nxt = 8'd0;
            end else begin
              sync_miss = 1'b1;
              miss_nxt  = miss + 8'd1;
              // Losing lock drops this byte; the previous packet already closed with eop.
              if (miss_nxt == 8'(LOSS_THR)) begin
                state_nxt = HUNT;
                idx_nxt   = '0;
                good_nxt  = 8'd0;
                miss_nxt  = 8'd0;
                emit      = 1'b0;
              end
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= HUNT;
      byte_idx       <= '0;
      good           <= 8'd0;
      miss           <= 8'd0;
      rd_pend        <= 1'b0;
      skid_vld       <= 1'b0;
      skid_data      <= 8'h00;
      skid_sop       <= 1'b0;
      skid_eop       <= 1'b0;
      ts_valid       <= 1'b0;
      ts_data        <= 8'h00;
      ts_sop         <= 1'b0;
      ts_eop         <= 1'b0;
      pkt_count      <= 32'd0;
      sync_err_count <= 32'd0;
    end else begin
      state    <= state_nxt;
      byte_idx <= idx_nxt;
      good     <= good_nxt;
      miss     <= miss_nxt;
      rd_pend  <= rd_req;

      // A word only lands while the skid is full if out_ready was low, which also blocked its read.
      if (out_free) begin
        if (skid_vld) begin
          ts_valid <= 1'b1;
          ts_data  <= skid_data;
          ts_sop   <= skid_sop;
          ts_eop   <= skid_eop;
          skid_vld <= 1'b0;
        end else if (emit) begin
          ts_valid <= 1'b1;
          ts_data  <= w_data;
          ts_sop   <= (byte_idx == '0);
          ts_eop   <= (byte_idx == LAST_IDX);
        end else begin
          ts_valid <= 1'b0;
          ts_sop   <= 1'b0;
          ts_eop   <= 1'b0;
        end
      end else if (emit) begin
        skid_vld  <= 1'b1;
        skid_data <= w_data;
        skid_sop  <= (byte_idx == '0);
        skid_eop  <= (byte_idx == LAST_IDX);
      end

      if (ts_valid && out_ready && ts_eop) pkt_count <= pkt_count + 32'd1;
      if (sync_miss && (sync_err_count != 32'hFFFF_FFFF)) sync_err_count <= sync_err_count + 32'd1;
    end
  end

endmodule
